// File: rtl/sram_block_engine.sv
// Block-command controller for a single-port SRAM: constant/incrementing fill, read-checksum, copy.
// All outputs registered; FILL 1, SUM 2, COPY 3 cycles per word, plus one DONE cycle.
module sram_block_engine #(
  parameter int A_WIDTH   = 13,
  parameter int D_WIDTH   = 8,
  parameter int SUM_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic [A_WIDTH-1:0]   Src_Addr,
  input  logic [A_WIDTH-1:0]   Dst_Addr,
  input  logic [A_WIDTH:0]     Length,
  input  logic [D_WIDTH-1:0]   Fill_Data,
  output logic                 Busy,
  output logic                 Done,
  output logic [SUM_WIDTH-1:0] Checksum,
  output logic [A_WIDTH-1:0]   Mem_Addr,
  output logic                 Mem_RW,
  output logic                 Mem_En,
  output logic [D_WIDTH-1:0]   Mem_Data_Out,
  input  logic [D_WIDTH-1:0]   Mem_Data_In
);

  localparam logic [1:0] OP_FILL_INC = 2'b01;
  localparam logic [1:0] OP_SUM      = 2'b10;
  localparam logic [1:0] OP_COPY     = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_CP_WR, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_op;
  logic [A_WIDTH-1:0]   r_src;
  logic [A_WIDTH-1:0]   r_dst;
  logic [A_WIDTH:0]     r_len;
  logic [D_WIDTH-1:0]   r_fill;
  logic [A_WIDTH:0]     r_idx;
  logic [A_WIDTH:0]     w_idx_next;
  logic [1:0]           w_op;
  logic [A_WIDTH-1:0]   w_src;
  logic [A_WIDTH-1:0]   w_dst;
  logic [D_WIDTH-1:0]   w_fill;
  logic                 w_last;
  logic                 w_start;
  logic                 w_mem_en;
  logic                 w_mem_rw;
  logic [A_WIDTH-1:0]   w_mem_addr;
  logic [D_WIDTH-1:0]   w_mem_dat;

  // Outputs are loaded from the next state, so in IDLE the command fields come straight from the inputs.
  assign w_start = (r_state == S_IDLE) && Start;
  assign w_op    = (r_state == S_IDLE) ? Op        : r_op;
  assign w_src   = (r_state == S_IDLE) ? Src_Addr  : r_src;
  assign w_dst   = (r_state == S_IDLE) ? Dst_Addr  : r_dst;
  assign w_fill  = (r_state == S_IDLE) ? Fill_Data : r_fill;
  assign w_last  = ((r_idx + {{A_WIDTH{1'b0}}, 1'b1}) == r_len);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_op    <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
      if (w_start) begin
        r_op   <= Op;
        r_src  <= Src_Addr;
        r_dst  <= Dst_Addr;
        r_len  <= Length;
        r_fill <= Fill_Data;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_idx_next = '0;
          if (Length == '0)  w_next = S_DONE;
          else if (!Op[1])   w_next = S_WR;
          else               w_next = S_RD_REQ;
        end
      end
      S_WR: begin
        if (w_last) w_next = S_DONE;
        else        w_idx_next = r_idx + 1'b1;
      end
      S_RD_REQ: w_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (r_op == OP_COPY) begin
          w_next = S_CP_WR;
        end else if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next     = S_RD_REQ;
          w_idx_next = r_idx + 1'b1;
        end
      end
      S_CP_WR: begin
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next     = S_RD_REQ;
          w_idx_next = r_idx + 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_en   = 1'b0;
    w_mem_rw   = 1'b0;
    w_mem_addr = Mem_Addr;
    w_mem_dat  = Mem_Data_Out;
    case (w_next)
      S_WR: begin
        w_mem_en   = 1'b1;
        w_mem_rw   = 1'b1;
        w_mem_addr = w_dst + w_idx_next[A_WIDTH-1:0];
        w_mem_dat  = (w_op == OP_FILL_INC) ? (w_fill + w_idx_next[D_WIDTH-1:0]) : w_fill;
      end
      S_RD_REQ: begin
        w_mem_en   = 1'b1;
        w_mem_addr = w_src + w_idx_next[A_WIDTH-1:0];
      end
      S_CP_WR: begin
        // The read word is valid only during RD_WAIT, so it is captured directly into the write data.
        w_mem_en   = 1'b1;
        w_mem_rw   = 1'b1;
        w_mem_addr = w_dst + w_idx_next[A_WIDTH-1:0];
        w_mem_dat  = Mem_Data_In;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Checksum     <= '0;
      Mem_Addr     <= '0;
      Mem_RW       <= 1'b0;
      Mem_En       <= 1'b0;
      Mem_Data_Out <= '0;
    end else begin
      Busy         <= (w_next != S_IDLE);
      Done         <= (w_next == S_DONE);
      Mem_Addr     <= w_mem_addr;
      Mem_RW       <= w_mem_rw;
      Mem_En       <= w_mem_en;
      Mem_Data_Out <= w_mem_dat;
      if (w_start && (Op == OP_SUM))
        Checksum <= '0;
      else if ((r_state == S_RD_WAIT) && (r_op == OP_SUM))
        Checksum <= Checksum + {{(SUM_WIDTH-D_WIDTH){1'b0}}, Mem_Data_In};
    end
  end

endmodule

// File: tb/tb_sram_block_engine.sv
// Drives block commands at sram_block_engine with an attached SRAM model and scoreboards every bus access.
module tb_sram_block_engine;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [1:0]  Op;
  logic [12:0] Src_Addr;
  logic [12:0] Dst_Addr;
  logic [13:0] Length;
  logic [7:0]  Fill_Data;
  logic        Busy;
  logic        Done;
  logic [15:0] Checksum;
  logic [12:0] Mem_Addr;
  logic        Mem_RW;
  logic        Mem_En;
  logic [7:0]  Mem_Data_Out;
  logic [7:0]  Mem_Data_In;

  typedef struct packed {
    int          cyc;
    logic        rw;
    logic [12:0] addr;
    logic [7:0]  dat;
  } acc_t;

  acc_t        exp_q[$];
  int          done_q[$];
  logic [7:0]  sram    [0:8191];
  logic [7:0]  exp_mem [0:8191];
  logic [15:0] exp_sum;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          n_left;

  sram_block_engine #(.A_WIDTH(13), .D_WIDTH(8), .SUM_WIDTH(16)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .Src_Addr(Src_Addr), .Dst_Addr(Dst_Addr),
    .Length(Length), .Fill_Data(Fill_Data), .Busy(Busy), .Done(Done), .Checksum(Checksum),
    .Mem_Addr(Mem_Addr), .Mem_RW(Mem_RW), .Mem_En(Mem_En), .Mem_Data_Out(Mem_Data_Out),
    .Mem_Data_In(Mem_Data_In)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // SRAM: read latency 1, output forced to 0 when not reading.
  always @(posedge Clk) begin
    if (Mem_En && Mem_RW) sram[Mem_Addr] <= Mem_Data_Out;
    if (Mem_En && !Mem_RW) Mem_Data_In <= sram[Mem_Addr];
    else                   Mem_Data_In <= 8'h00;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  always @(negedge Clk) begin
    acc_t e;
    int   d;
    if (!Rst) begin
      if (Mem_En) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_access cyc=%0d addr=%0h rw=%0b", cyc, Mem_Addr, Mem_RW);
        end else begin
          e = exp_q.pop_front();
          check("access{cyc,rw,addr,dat}",
                {10'd0, cyc, Mem_RW, Mem_Addr, (Mem_RW ? Mem_Data_Out : 8'h00)},
                {10'd0, e.cyc, e.rw, e.addr, e.dat});
        end
      end
      if (Done) begin
        if (done_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done cyc=%0d", cyc);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(d));
        end
      end
    end
  end

  task automatic push(input int c, input logic rw, input logic [12:0] a, input logic [7:0] d,
                      output bit ok);
    ok = 1'b0;
    if (n_left > 0) begin
      exp_q.push_back('{cyc: c, rw: rw, addr: a, dat: d});
      n_left--;
      ok = 1'b1;
    end
  endtask

  // Reference model: expected accesses and memory effect straight from the command's word rules.
  task automatic gen(input logic [1:0] op, input logic [12:0] src, input logic [12:0] dst,
                     input int len, input logic [7:0] fill, input int sc);
    logic [12:0] as, ad;
    logic [7:0]  w;
    bit          ok;
    if (op == 2'b10) exp_sum = 16'h0;
    for (int i = 0; i < len; i++) begin
      as = src + 13'(i);
      ad = dst + 13'(i);
      case (op)
        2'b00, 2'b01: begin
          w = (op == 2'b01) ? (fill + 8'(i)) : fill;
          push(sc + i, 1'b1, ad, w, ok);
          if (ok) exp_mem[ad] = w;
        end
        2'b10: begin
          push(sc + 2*i, 1'b0, as, 8'h00, ok);
          if (ok) exp_sum = exp_sum + 16'(exp_mem[as]);
        end
        default: begin
          w = exp_mem[as];
          push(sc + 3*i, 1'b0, as, 8'h00, ok);
          if (ok) push(sc + 3*i + 2, 1'b1, ad, w, ok);
          if (ok) exp_mem[ad] = w;
        end
      endcase
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [12:0] src, input logic [12:0] dst,
                         input int len, input logic [7:0] fill, input bit hold);
    int sc, cost, busy_n;
    cost = (op[1] == 1'b0) ? 1 : ((op == 2'b10) ? 2 : 3);
    @(negedge Clk);
    sc     = cyc + 1;
    n_left = 1 << 30;
    gen(op, src, dst, len, fill, sc);
    done_q.push_back(sc + len * cost);
    Op = op; Src_Addr = src; Dst_Addr = dst; Length = 14'(len); Fill_Data = fill;
    Start  = 1'b1;
    busy_n = 0;
    for (int k = 0; k < 40000; k++) begin
      @(negedge Clk);
      if (!hold || Done) Start = 1'b0;
      if (Busy) busy_n++;
      else break;
    end
    Start = 1'b0;
    check("busy_cycles", 64'(busy_n), 64'(len * cost + 1));
    check("pending_events", 64'(exp_q.size() + done_q.size()), 64'd0);
    if (op == 2'b10) check("checksum", 64'(Checksum), 64'(exp_sum));
  endtask

  task automatic reset_mid_copy();
    int sc;
    @(negedge Clk);
    sc     = cyc + 1;
    n_left = 3;
    gen(2'b11, 13'h010, 13'h300, 4, 8'h00, sc);
    Op = 2'b11; Src_Addr = 13'h010; Dst_Addr = 13'h300; Length = 14'd4;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    #2 Rst = 1'b1;
    exp_sum = 16'h0;
    #1;
    check("abort_outputs", {26'd0, Busy, Done, Checksum, Mem_Addr, Mem_RW, Mem_En, Mem_Data_Out}, 64'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (12) @(negedge Clk);
    check("abort_pending", 64'(exp_q.size()), 64'd0);
    check("abort_no_write", 64'(sram[13'h301]), 64'(exp_mem[13'h301]));
    check("abort_idle", {62'd0, Busy, Mem_En}, 64'd0);
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 8192; i++) begin
      v = 8'($urandom);
      sram[i] = v;
      exp_mem[i] = v;
    end
    exp_sum = 16'h0;
    Rst = 1'b1; Start = 1'b0; Op = 2'b00; Src_Addr = '0; Dst_Addr = '0; Length = '0; Fill_Data = '0;
    #3;
    check("reset_outputs", {26'd0, Busy, Done, Checksum, Mem_Addr, Mem_RW, Mem_En, Mem_Data_Out}, 64'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    run_cmd(2'b00, 13'h0000, 13'h0010, 4, 8'hA5, 1'b0);
    run_cmd(2'b01, 13'h0000, 13'h1FFE, 4, 8'hFE, 1'b0);
    run_cmd(2'b10, 13'h0010, 13'h0000, 4, 8'h00, 1'b0);
    check("sum_a5x4", 64'(Checksum), 64'h0294);
    run_cmd(2'b11, 13'h0010, 13'h0100, 4, 8'h00, 1'b0);
    run_cmd(2'b10, 13'h0100, 13'h0000, 4, 8'h00, 1'b0);
    check("copy_readback", 64'(Checksum), 64'h0294);
    reset_mid_copy();
    check("abort_checksum", 64'(Checksum), 64'd0);

    for (int op = 0; op < 4; op++) run_cmd(2'(op), 13'h0123, 13'h0456, 0, 8'h11, 1'b1);
    run_cmd(2'b11, 13'h0200, 13'h0202, 10, 8'h00, 1'b1);
    run_cmd(2'b11, 13'h1FFC, 13'h0FFE, 8, 8'h00, 1'b0);
    run_cmd(2'b01, 13'h0000, 13'h1000, 8192, 8'h37, 1'b0);
    run_cmd(2'b10, 13'h0800, 13'h0000, 8192, 8'h00, 1'b0);

    for (int n = 0; n < 24; n++) begin
      run_cmd(2'($urandom_range(0, 3)), 13'($urandom), 13'($urandom),
              int'($urandom_range(0, 40)), 8'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
